grf_fwd_unit: RTL and testbench
===============================

Name: grf_fwd_unit

Overview:
- Parametrised successor to the D-stage operand path: register file, multi-stage forwarding and hazard stall in one block.
- Holds NUM_REGS x DATA_W registers and serves NUM_RD read ports.
- Resolves each read against in-flight producers (E, M, ... stages, priority youngest-first) with write-through from the W port.
- Raises a stall when a needed operand is still being produced. Provides the branch comparator results for ports 0 and 1.

Parameters:
- DATA_W, 32, register/data width (>=2).
- NUM_REGS, 32, register count, power of two; register 0 hardwired to zero.
- NUM_RD, 2, read ports (>=2; ports 0/1 feed the comparator).
- FWD_STAGES, 2, forwarding sources; index 0 = youngest (E), highest priority.
- AW, $clog2(NUM_REGS), address width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers.
- we  in  1  W-stage write enable.
- wa  in  AW  write address.
- wd  in  DATA_W  write data.
- rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW].
- rd_use  in  NUM_RD  port i operand needed this cycle by the D-stage instruction.
- rd_data  out  NUM_RD*DW  resolved operands.
- fwd_valid  in  FWD_STAGES  stage s writes a register.
- fwd_addr  in  FWD_STAGES*AW  destination of stage s.
- fwd_ready  in  FWD_STAGES  stage s result available now (Tnew==0).
- fwd_data  in  FWD_STAGES*DW  stage s result; meaningful only when ready.
- mdu_busy  in  1  multiply/divide unit busy.
- mdu_use  in  1  D-stage instruction touches HI/LO.
- stall  out  1  freeze PC/D register, bubble E.
- cmp_eq  out  1  rd_data port0 == port1.
- cmp_sign  out  2  port0 class: 0 zero, 1 positive, 2 negative.
- fwd_hits  out  32  saturating count of forwarded reads (perf).

Behaviour:
- Storage: array updated on posedge clk when we && wa!=0. Reset (async) clears all entries and fwd_hits to 0. Writes to address 0 are ignored; reads of address 0 return 0 regardless of forwarding.
- Read resolution per port i, purely combinational, priority order:
  - (1) addr==0 -> 0.
  - (2) lowest s with fwd_valid[s] && fwd_addr[s]==addr: if fwd_ready[s], return fwd_data[s]; else the operand is unresolved. Older stages are never consulted past the first match.
  - (3) we && wa==addr -> wd (write-through, same cycle).
  - (4) array value.
- Matching stages with fwd_addr==0 never count as a match.
- stall = mdu_busy && mdu_use, OR any port i with rd_use[i] and an unresolved operand. An unused port never stalls. When stalled, rd_data still shows the step-(2)-or-later value; the consumer ignores it.
- cmp_eq and cmp_sign are combinational on the resolved port 0/1 values. Encoding 3 is never produced.
- fwd_hits: increments by 1 per posedge for each cycle with !stall and at least one used port resolved via step (2). Saturates at 32'hFFFFFFFF.
- Latency: write visible to reads in the same cycle (bypass) and from the array thereafter. No read latency.
- Simultaneous write of the same address by W and a matching older stage: the stage value wins by priority.
- Reset mid-stall: stall follows inputs combinationally; only storage and counter are reset.

Decomposition:
- Shared package: cmp_sign encodings (CMP_ZERO=0, CMP_POS=1, CMP_NEG=2) and the default DATA_W/NUM_REGS constants.
- One sub-module, fwd_resolve: a single-port priority resolver (addr, use, fwd bus, write port, array value -> data, unresolved, hit), instantiated NUM_RD times.

Test Plan:
- Reset, then write r5=0x12345678 at cycle 1 and read port0=r5 the same cycle -> rd_data0=0x12345678 via bypass; next cycle still 0x12345678 from the array.
- Write r0=0xFFFFFFFF; read r0 with fwd_valid[0], fwd_addr=0, fwd_data=7 -> rd_data=0, stall=0.
- Stage0 (r3, ready, 0xAA) and stage1 (r3, ready, 0xBB) -> port reads 0xAA, fwd_hits increments by 1.
- Stage0 (r3, not ready), rd_use0=1, port0=r3 -> stall=1. Same with rd_use0=0 -> stall=0.
- Port0=r1=0x80000000, port1=r2=0x80000000 -> cmp_eq=1, cmp_sign=2. Then r1=0 -> cmp_eq=0, cmp_sign=0.
- mdu_busy=1 && mdu_use=1 -> stall=1. Assert reset mid-cycle -> all reads return 0 and fwd_hits=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/grf_fwd_unit_pkg.sv
// Shared constants for the D-stage operand path.
// Defines comparator sign classes and default register file sizing.
package grf_fwd_unit_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  typedef enum logic [1:0] {
    CMP_ZERO = 2'd0,
    CMP_POS  = 2'd1,
    CMP_NEG  = 2'd2
  } cmp_sign_e;

endpackage

// File: rtl/grf_fwd_unit_resolve.sv
// fwd_resolve: single read port priority resolver.
// Ports: addr/used in, fwd bus in, write port in, arr_val in;
// data, unresolved (used and producer not ready), hit (used, forwarded) out.
module fwd_resolve #(
  parameter int DATA_W     = 32,
  parameter int AW         = 5,
  parameter int FWD_STAGES = 2
) (
  input  logic [AW-1:0]                addr,
  input  logic                         used,
  input  logic [FWD_STAGES-1:0]        fwd_valid,
  input  logic [FWD_STAGES*AW-1:0]     fwd_addr,
  input  logic [FWD_STAGES-1:0]        fwd_ready,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [DATA_W-1:0]            wd,
  input  logic [DATA_W-1:0]            arr_val,
  output logic [DATA_W-1:0]            data,
  output logic                         unresolved,
  output logic                         hit
);

  logic matched;
  logic ready_m;

  always_comb begin
    data       = '0;
    unresolved = 1'b0;
    hit        = 1'b0;
    matched    = 1'b0;
    ready_m    = 1'b0;
    if (addr != '0) begin
      // youngest stage first; the first match hides all older ones
      for (int s = 0; s < FWD_STAGES; s++) begin
        if (!matched && fwd_valid[s] &&
            fwd_addr[s*AW +: AW] == addr) begin
          matched = 1'b1;
          ready_m = fwd_ready[s];
          if (fwd_ready[s])
            data = fwd_data[s*DATA_W +: DATA_W];
        end
      end
      // an unready producer falls through; consumer is stalled anyway
      if (!matched || !ready_m) begin
        if (we && wa == addr)
          data = wd;
        else
          data = arr_val;
      end
      unresolved = used && matched && !ready_m;
      hit        = used && matched && ready_m;
    end
  end

endmodule

// File: rtl/grf_fwd_unit.sv
// grf_fwd_unit: register file with multi-stage forwarding,
// hazard stall, branch comparator and forwarded-read counter.
// Ports: clk, reset (async high), W write port (we/wa/wd),
// read ports (rd_addr/rd_use -> rd_data), forwarding bus
// (fwd_valid/fwd_addr/fwd_ready/fwd_data), mdu_busy/mdu_use,
// outputs stall, cmp_eq, cmp_sign, fwd_hits.
module grf_fwd_unit
  import grf_fwd_unit_pkg::*;
#(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int NUM_REGS   = DEF_NUM_REGS,
  parameter  int NUM_RD     = 2,
  parameter  int FWD_STAGES = 2,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [AW-1:0]                wa,
  input  logic [DATA_W-1:0]            wd,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  input  logic [NUM_RD-1:0]            rd_use,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic [FWD_STAGES-1:0]        fwd_valid,
  input  logic [FWD_STAGES*AW-1:0]     fwd_addr,
  input  logic [FWD_STAGES-1:0]        fwd_ready,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         mdu_busy,
  input  logic                         mdu_use,
  output logic                         stall,
  output logic                         cmp_eq,
  output logic [1:0]                   cmp_sign,
  output logic [31:0]                  fwd_hits
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_RD-1:0] unres;
  logic [NUM_RD-1:0] hits;
  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    fwd_resolve #(
      .DATA_W     (DATA_W),
      .AW         (AW),
      .FWD_STAGES (FWD_STAGES)
    ) u_res (
      .addr       (rd_addr[i*AW +: AW]),
      .used       (rd_use[i]),
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_ready  (fwd_ready),
      .fwd_data   (fwd_data),
      .we         (we),
      .wa         (wa),
      .wd         (wd),
      .arr_val    (regs[rd_addr[i*AW +: AW]]),
      .data       (rd_data[i*DATA_W +: DATA_W]),
      .unresolved (unres[i]),
      .hit        (hits[i])
    );
  end

  assign stall = (mdu_busy && mdu_use) || (|unres);

  assign op0 = rd_data[0 +: DATA_W];
  assign op1 = rd_data[DATA_W +: DATA_W];

  always_comb begin
    cmp_eq   = (op0 == op1);
    cmp_sign = CMP_POS;
    if (op0 == '0)
      cmp_sign = CMP_ZERO;
    else if (op0[DATA_W-1])
      cmp_sign = CMP_NEG;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
      fwd_hits <= '0;
    end else begin
      if (we && wa != '0)
        regs[wa] <= wd;
      if (!stall && (|hits) && fwd_hits != 32'hFFFF_FFFF)
        fwd_hits <= fwd_hits + 32'd1;
    end
  end

endmodule

// File: tb/tb_grf_fwd_unit.sv
// Self-checking bench for grf_fwd_unit.
// Directed scenarios plus random traffic against a reference model.
module tb_grf_fwd_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra [2];
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  fv;
  logic [4:0]  fa [2];
  logic [1:0]  fr;
  logic [31:0] fd [2];
  logic        mdu_busy, mdu_use;
  logic        stall, cmp_eq;
  logic [1:0]  cmp_sign;
  logic [31:0] fwd_hits;

  logic [9:0]  rd_addr;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic [31:0] rd0, rd1;

  assign rd_addr  = {ra[1], ra[0]};
  assign fwd_addr = {fa[1], fa[0]};
  assign fwd_data = {fd[1], fd[0]};
  assign rd0 = rd_data[31:0];
  assign rd1 = rd_data[63:32];

  int total = 0;
  int bad = 0;

  logic [31:0] mregs [32];
  logic [31:0] mhits;

  always #5 clk = ~clk;

  grf_fwd_unit dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .rd_addr   (rd_addr),
    .rd_use    (rd_use),
    .rd_data   (rd_data),
    .fwd_valid (fv),
    .fwd_addr  (fwd_addr),
    .fwd_ready (fr),
    .fwd_data  (fwd_data),
    .mdu_busy  (mdu_busy),
    .mdu_use   (mdu_use),
    .stall     (stall),
    .cmp_eq    (cmp_eq),
    .cmp_sign  (cmp_sign),
    .fwd_hits  (fwd_hits)
  );

  // Reference read: what the operand should be per the resolution rules.
  function automatic void mres(input logic [4:0] a,
                               output logic [31:0] d,
                               output bit unr,
                               output bit hit);
    d = 0; unr = 0; hit = 0;
    if (a == 0) return;
    for (int s = 0; s < 2; s++) begin
      if (fv[s] && fa[s] == a) begin
        if (fr[s]) begin
          d = fd[s];
          hit = 1;
        end else begin
          unr = 1;
        end
        return;
      end
    end
    d = (we && wa == a) ? wd : mregs[a];
  endfunction

  function automatic bit mstall();
    logic [31:0] d;
    bit u, h, st;
    st = mdu_busy && mdu_use;
    for (int p = 0; p < 2; p++) begin
      mres(ra[p], d, u, h);
      if (rd_use[p] && u) st = 1;
    end
    return st;
  endfunction

  function automatic bit many_hit();
    logic [31:0] d;
    bit u, h, any;
    any = 0;
    for (int p = 0; p < 2; p++) begin
      mres(ra[p], d, u, h);
      if (rd_use[p] && h) any = 1;
    end
    return any;
  endfunction

  task automatic idle();
    we = 0; wa = 0; wd = 0;
    ra[0] = 0; ra[1] = 0; rd_use = 0;
    fv = 0; fr = 0;
    fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
    mdu_busy = 0; mdu_use = 0;
  endtask

  task automatic tick();
    bit st, hh;
    st = mstall();
    hh = many_hit();
    @(posedge clk);
    if (we && wa != 0) mregs[wa] = wd;
    if (!st && hh && mhits != 32'hFFFF_FFFF) mhits = mhits + 1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    for (int r = 0; r < 32; r++) mregs[r] = 0;
    mhits = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    ra[0] = 5; rd_use = 2'b01;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++; $display("FAIL reset_rd0 got=%h exp=0", rd0);
    end
    total++;
    if (fwd_hits !== 32'h0) begin
      bad++; $display("FAIL reset_hits got=%0d exp=0", fwd_hits);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b exp=0", stall);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    we = 1; wa = 5; wd = 32'h1234_5678;
    ra[0] = 5; rd_use = 2'b01;
    #1;
    total++;
    if (rd0 !== 32'h1234_5678) begin
      bad++; $display("FAIL bypass got=%h exp=12345678", rd0);
    end
    tick();
    we = 0;
    #1;
    total++;
    if (rd0 !== 32'h1234_5678) begin
      bad++; $display("FAIL array_read got=%h exp=12345678", rd0);
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    idle();
    we = 1; wa = 0; wd = 32'hFFFF_FFFF;
    ra[0] = 0; rd_use = 2'b01;
    fv = 2'b01; fa[0] = 0; fr = 2'b01; fd[0] = 7;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++; $display("FAIL r0_fwd got=%h exp=0", rd0);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL r0_stall got=%b exp=0", stall);
    end
    tick();
    idle();
    rd_use = 2'b01;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++; $display("FAIL r0_array got=%h exp=0", rd0);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle();
    fv = 2'b11; fr = 2'b11;
    fa[0] = 3; fa[1] = 3; fd[0] = 32'hAA; fd[1] = 32'hBB;
    ra[0] = 3; rd_use = 2'b01;
    #1;
    total++;
    if (rd0 !== 32'hAA) begin
      bad++; $display("FAIL prio got=%h exp=aa", rd0);
    end
    tick();
    total++;
    if (fwd_hits !== 32'd1) begin
      bad++; $display("FAIL prio_hits got=%0d exp=1", fwd_hits);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle();
    fv = 2'b01; fa[0] = 3; fr = 2'b00;
    ra[0] = 3; rd_use = 2'b01;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL stall_used got=%b exp=1", stall);
    end
    rd_use = 2'b00;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL stall_unused got=%b exp=0", stall);
    end
    rd_use = 2'b01;
    fv = 2'b11; fa[1] = 3; fr = 2'b10; fd[1] = 32'hBB;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL stall_shadow got=%b exp=1", stall);
    end
    tick();
    total++;
    if (fwd_hits !== 32'd1) begin
      bad++; $display("FAIL stall_nohit got=%0d exp=1", fwd_hits);
    end
  endtask

  task automatic test_cmp();
    @(negedge clk);
    idle();
    we = 1; wa = 1; wd = 32'h8000_0000;
    tick();
    wa = 2;
    tick();
    we = 0;
    ra[0] = 1; ra[1] = 2; rd_use = 2'b11;
    #1;
    total++;
    if (cmp_eq !== 1'b1 || cmp_sign !== 2'd2) begin
      bad++;
      $display("FAIL cmp_neg got=%b/%0d exp=1/2", cmp_eq, cmp_sign);
    end
    we = 1; wa = 1; wd = 0;
    #1;
    total++;
    if (cmp_eq !== 1'b0 || cmp_sign !== 2'd0) begin
      bad++;
      $display("FAIL cmp_zero got=%b/%0d exp=0/0", cmp_eq, cmp_sign);
    end
    tick();
    we = 1; wa = 4; wd = 5; ra[0] = 4;
    #1;
    total++;
    if (cmp_eq !== 1'b0 || cmp_sign !== 2'd1) begin
      bad++;
      $display("FAIL cmp_pos got=%b/%0d exp=0/1", cmp_eq, cmp_sign);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] d [2];
    bit u [2];
    bit h [2];
    logic [31:0] pool [4];
    logic [31:0] rds [2];
    logic [31:0] ed;
    pool[0] = 32'h0; pool[1] = 32'h8000_0001;
    pool[2] = 32'h7FFF_FFFF; pool[3] = 32'h0000_00A5;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we = 1'($urandom);
      wa = 5'($urandom_range(0, 7));
      wd = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)]
                                       : $urandom;
      for (int p = 0; p < 2; p++) begin
        ra[p] = 5'($urandom_range(0, 7));
        fa[p] = 5'($urandom_range(0, 7));
        fd[p] = $urandom;
      end
      rd_use = 2'($urandom);
      fv = 2'($urandom);
      fr = 2'($urandom);
      mdu_busy = ($urandom_range(0, 7) == 0);
      mdu_use = 1'($urandom);
      #1;
      rds[0] = rd0; rds[1] = rd1;
      for (int p = 0; p < 2; p++) begin
        mres(ra[p], d[p], u[p], h[p]);
        if (!u[p]) begin
          total++;
          if (rds[p] !== d[p]) begin
            bad++;
            $display("FAIL rnd_rd%0d n=%0d got=%h exp=%h",
                     p, n, rds[p], d[p]);
          end
        end
      end
      total++;
      if (stall !== mstall()) begin
        bad++;
        $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, mstall());
      end
      if (!u[0] && !u[1]) begin
        ed = d[0];
        total++;
        if (cmp_eq !== (d[0] == d[1])) begin
          bad++;
          $display("FAIL rnd_eq n=%0d got=%b", n, cmp_eq);
        end
        total++;
        if (cmp_sign !== ((ed == 0) ? 2'd0 : (ed[31] ? 2'd2 : 2'd1))) begin
          bad++;
          $display("FAIL rnd_sign n=%0d got=%0d op0=%h", n, cmp_sign, ed);
        end
      end
      tick();
      total++;
      if (fwd_hits !== mhits) begin
        bad++;
        $display("FAIL rnd_hits n=%0d got=%0d exp=%0d", n, fwd_hits, mhits);
      end
    end
  endtask

  task automatic test_mdu_reset();
    @(negedge clk);
    idle();
    mdu_busy = 1; mdu_use = 1;
    ra[0] = 5; rd_use = 2'b01;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL mdu_stall got=%b exp=1", stall);
    end
    #1;
    reset = 1;
    for (int r = 0; r < 32; r++) mregs[r] = 0;
    mhits = 0;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++; $display("FAIL rst_mid_rd got=%h exp=0", rd0);
    end
    total++;
    if (fwd_hits !== 32'h0) begin
      bad++; $display("FAIL rst_mid_hits got=%0d exp=0", fwd_hits);
    end
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL rst_mid_stall got=%b exp=1", stall);
    end
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_priority();
    test_stall();
    test_cmp();
    test_random();
    test_mdu_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
